// File: rtl/updown_counter_pkg.sv
// updown_counter_pkg: shared direction/mode constants and a clog2 helper for sizing the prescaler
package updown_counter_pkg;
    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction
endpackage

// File: rtl/updown_counter_prescaler.sv
// counter_prescaler: emits a tick on every PRESCALE-th enabled cycle; clr and rst restart the phase
module counter_prescaler
    import updown_counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int unsigned W = (clog2(PRESCALE) > 0) ? clog2(PRESCALE) : 1;
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // phase counter advances only on enabled cycles and wraps on the tick
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/updown_counter.sv
// updown_counter: loadable up/down counter with wrap/saturate boundaries and an overflow pulse;
// define UPDOWN_COUNTER_PRESCALE_EN to step only every PRESCALE-th enabled cycle
module updown_counter
    import updown_counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 1,
    parameter int unsigned     PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             dir,
    input  logic             sat,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             zero
);
    localparam logic [WIDTH:0] MAXV = MAX_VAL[WIDTH:0];

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("updown_counter: WIDTH out of range");
    end
    if (MAX_VAL < 1 || MAX_VAL > (64'd1 << WIDTH) - 1) begin : g_bad_max
        $error("updown_counter: MAX_VAL out of range");
    end
    if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_pre
        $error("updown_counter: PRESCALE out of range");
    end

    logic             tick;
    logic             up;
    logic             hit;
    logic [WIDTH:0]   cur;
    logic [WIDTH:0]   inc;
    logic [WIDTH:0]   dec;
    logic [WIDTH:0]   ldw;
    logic [WIDTH:0]   ldv;
    logic [WIDTH-1:0] nxt;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
    counter_prescaler #(.PRESCALE(PRESCALE)) u_pre (
        .clk  (clk),
        .rst  (rst),
        .clr  (load),
        .en   (en && !load),
        .tick (tick)
    );
`else
    assign tick = 1'b1;
`endif

    assign up   = (dir == DIR_UP);
    assign cur  = {1'b0, count};
    assign inc  = cur + 1'b1;
    assign dec  = cur - 1'b1;
    assign ldw  = {1'b0, data_in};
    assign ldv  = (ldw > MAXV) ? MAXV : ldw;
    assign zero = (count == '0);

    // boundary compare and next-step value; at a boundary saturate holds, wrap jumps to the far end
    always_comb begin
        hit = up ? (cur == MAXV) : (count == '0);
        nxt = hit ? ((sat == MODE_SAT) ? count : (up ? '0 : MAXV[WIDTH-1:0]))
                  : (up ? inc[WIDTH-1:0] : dec[WIDTH-1:0]);
    end

    // count and ovf registers with rst > load > step > hold priority
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (load) begin
            count <= ldv[WIDTH-1:0];
            ovf   <= 1'b0;
        end else if (en && tick) begin
            count <= nxt;
            ovf   <= hit;
        end else begin
            ovf   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_updown_counter.sv
// tb_updown_counter: directed vector table plus randomized checking against a behavioural model
module tb_updown_counter;
    localparam int W    = 4;
    localparam int MAXV = 9;
    localparam int PRE  = 3;
`ifdef UPDOWN_COUNTER_PRESCALE_EN
    localparam int PSTEP = PRE;
`else
    localparam int PSTEP = 1;
`endif

    logic         clk = 0;
    logic         rst, en, load, dir, sat;
    logic [W-1:0] data_in;
    logic [W-1:0] count;
    logic         ovf, zero;

    int checks = 0;
    int failures = 0;

    int m_cnt, m_ph;
    bit m_ovf;

    typedef struct {
        logic r, l, e, d, s;
        logic [W-1:0] din;
        int cnt;
        logic ovf, zero;
    } vec_t;
    vec_t tbl[$];

    updown_counter #(.WIDTH(W), .MAX_VAL(MAXV), .PRESCALE(PRE)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .data_in(data_in),
        .dir(dir), .sat(sat), .count(count), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic r, l, e, d, s, input logic [W-1:0] din);
        rst = r; load = l; en = e; dir = d; sat = s; data_in = din;
        @(posedge clk);
        #1;
    endtask

    function automatic void v(input logic r, l, e, d, s, input int din, input int c, input logic o, z);
        tbl.push_back('{r, l, e, d, s, W'(din), c, o, z});
    endfunction

    // specification-level reference: integer arithmetic, no knowledge of the RTL structure
    task automatic model(input logic r, l, e, d, s, input int din);
        int nv;
        m_ovf = 0;
        if (r) begin
            m_cnt = 0; m_ph = 0;
        end else if (l) begin
            m_cnt = (din > MAXV) ? MAXV : din; m_ph = 0;
        end else if (e) begin
            m_ph++;
            if (m_ph >= PSTEP) begin
                m_ph = 0;
                nv = d ? m_cnt + 1 : m_cnt - 1;
                if (nv < 0 || nv > MAXV) begin
                    m_ovf = 1;
                    if (!s) m_cnt = (nv < 0) ? MAXV : 0;
                end else m_cnt = nv;
            end
        end
    endtask

    initial begin
        logic r, l, e, d, s;
        int din;
        // reset state
        v(1, 0, 0, 0, 0, 0, 0, 0, 1);
`ifndef UPDOWN_COUNTER_PRESCALE_EN
        // wrap up 1..9,0,1 with ovf after 9->0
        for (int i = 1; i <= 11; i++)
            v(0, 0, 1, 1, 0, 0, i % 10, i == 10, (i % 10) == 0);
        // saturate down from 2
        v(0, 1, 0, 0, 0, 2, 2, 0, 0);
        v(0, 0, 1, 0, 1, 0, 1, 0, 0);
        v(0, 0, 1, 0, 1, 0, 0, 0, 1);
        v(0, 0, 1, 0, 1, 0, 0, 1, 1);
        v(0, 0, 1, 0, 1, 0, 0, 1, 1);
        // load clamp over en, then rst over load
        v(0, 1, 1, 1, 0, 14, 9, 0, 0);
        v(1, 1, 0, 0, 0, 5, 0, 0, 1);
        // direction change at boundary in wrap mode
        v(0, 0, 1, 0, 0, 0, 9, 1, 0);
        v(0, 0, 1, 1, 0, 0, 0, 1, 1);
        v(0, 0, 0, 1, 0, 0, 0, 0, 1);
        // saturate up at MAX holds and pulses
        v(0, 1, 0, 0, 0, 9, 9, 0, 0);
        v(0, 0, 1, 1, 1, 0, 9, 1, 0);
        v(0, 0, 0, 1, 1, 0, 9, 0, 0);
`else
        // prescale by 3: 0,0,1,1,1,2,2,2,3
        v(0, 0, 1, 1, 0, 0, 0, 0, 1);
        v(0, 0, 1, 1, 0, 0, 0, 0, 1);
        v(0, 0, 1, 1, 0, 0, 1, 0, 0);
        v(0, 0, 1, 1, 0, 0, 1, 0, 0);
        v(0, 0, 1, 1, 0, 0, 1, 0, 0);
        v(0, 0, 1, 1, 0, 0, 2, 0, 0);
        v(0, 0, 1, 1, 0, 0, 2, 0, 0);
        v(0, 0, 1, 1, 0, 0, 2, 0, 0);
        v(0, 0, 1, 1, 0, 0, 3, 0, 0);
        // en gap keeps phase
        v(0, 0, 0, 1, 0, 0, 3, 0, 0);
        v(0, 0, 0, 1, 0, 0, 3, 0, 0);
        v(0, 0, 1, 1, 0, 0, 3, 0, 0);
        v(0, 0, 1, 1, 0, 0, 3, 0, 0);
        v(0, 0, 1, 1, 0, 0, 4, 0, 0);
        // load mid-phase restarts the count
        v(0, 0, 1, 1, 0, 0, 4, 0, 0);
        v(0, 1, 1, 1, 0, 7, 7, 0, 0);
        v(0, 0, 1, 1, 0, 0, 7, 0, 0);
        v(0, 0, 1, 1, 0, 0, 7, 0, 0);
        v(0, 0, 1, 1, 0, 0, 8, 0, 0);
        // reset at phase 2 with count 7
        v(0, 1, 0, 1, 0, 7, 7, 0, 0);
        v(0, 0, 1, 1, 0, 0, 7, 0, 0);
        v(0, 0, 1, 1, 0, 0, 7, 0, 0);
        v(1, 0, 1, 1, 0, 0, 0, 0, 1);
        v(0, 0, 1, 1, 0, 0, 0, 0, 1);
        v(0, 0, 1, 1, 0, 0, 0, 0, 1);
        v(0, 0, 1, 1, 0, 0, 1, 0, 0);
`endif
        foreach (tbl[i]) begin
            apply(tbl[i].r, tbl[i].l, tbl[i].e, tbl[i].d, tbl[i].s, tbl[i].din);
            chk($sformatf("vec%0d.count", i), int'(count), tbl[i].cnt);
            chk($sformatf("vec%0d.ovf", i), int'(ovf), int'(tbl[i].ovf));
            chk($sformatf("vec%0d.zero", i), int'(zero), int'(tbl[i].zero));
        end

        // randomized run against the reference model
        apply(1, 0, 0, 0, 0, 0);
        model(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 49) == 0);
            l   = ($urandom_range(0, 7) == 0);
            e   = ($urandom_range(0, 3) != 0);
            d   = ($urandom_range(0, 9) < 6) ^ (i[7]);
            s   = $urandom_range(0, 1) == 1;
            din = $urandom_range(0, 15);
            apply(r, l, e, d, s, W'(din));
            model(r, l, e, d, s, din);
            chk("rand.count", int'(count), m_cnt);
            chk("rand.ovf", int'(ovf), int'(m_ovf));
            chk("rand.zero", int'(zero), int'(m_cnt == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/updown_counter.md
UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1: terminal value, so the count range is 0..MAX_VAL; legal range 1..2**WIDTH-1.
REQ-003 Parameter PRESCALE, default 4: number of enabled cycles per count step; legal range 1..256; used only when the prescaler is compiled in.
REQ-004 Port clk  input  1: the single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1: reset, synchronous and active-high.
REQ-006 Port en  input  1: count enable.
REQ-007 Port load  input  1: loads data_in.
REQ-008 Port data_in  input  WIDTH: load value.
REQ-009 Port dir  input  1: direction; 1 = up, 0 = down.
REQ-010 Port sat  input  1: boundary mode; 1 = saturate, 0 = wrap.
REQ-011 Port count  output  WIDTH: registered count value.
REQ-012 Port ovf  output  1: registered one-cycle pulse flagging an attempted step past a boundary.
REQ-013 Port zero  output  1: combinational flag, high while count == 0.

Function
REQ-014 Priority per cycle SHALL be rst > load > step > hold.
REQ-015 Load: count <= min(data_in, MAX_VAL) on the next edge; ovf SHALL be 0 in the following cycle; en, dir and sat are ignored in that cycle.
REQ-016 Step (en=1, no load, prescaler tick): up gives count+1 and down gives count-1, with dir and sat sampled in the same cycle.
REQ-017 Up step at count == MAX_VAL: wrap mode sets count to 0; saturate mode holds MAX_VAL.
REQ-018 Down step at count == 0: wrap mode sets count to MAX_VAL; saturate mode holds 0.
REQ-019 ovf SHALL be high for exactly the one cycle after any step attempted at a boundary (REQ-017/018), in both modes; repeated attempted steps give repeated pulses.
REQ-020 en=0 with no load: count holds and ovf is 0.
REQ-021 All next-count arithmetic SHALL be WIDTH+1 bits wide internally; count SHALL never exceed MAX_VAL.
REQ-022 Step latency: count reflects a step on the edge that samples en (one cycle).

Reset
REQ-023 On rst=1 at an edge: count=0, ovf=0, prescaler state=0; zero therefore reads 1.
REQ-024 A reset arriving mid-prescale or concurrent with load or en SHALL win with no residual state.

Configuration
REQ-025 Macro UPDOWN_COUNTER_PRESCALE_EN defined: a step occurs only on every PRESCALE-th cycle with en=1 and no load.
REQ-026 With the macro defined, cycles with en=0 freeze the prescaler, and load or rst clear it to 0.
REQ-027 With the macro defined, PRESCALE=1 SHALL behave identically to the macro being undefined.
REQ-028 Macro undefined: every en=1 cycle is a step, no prescaler logic is instantiated, and PRESCALE is ignored.

Structure
REQ-029 Package updown_counter_pkg SHALL hold the constants DIR_UP=1, DIR_DOWN=0, MODE_WRAP=0 and MODE_SAT=1, plus a function clog2 used to size the prescaler.
REQ-030 Sub-module counter_prescaler (parameter PRESCALE; ports clk, rst, clr, en, tick) SHALL be instantiated only under UPDOWN_COUNTER_PRESCALE_EN.
REQ-031 The top level SHALL contain only the count register, the ovf register, the boundary compare and the next-state mux.

Verification (WIDTH=4, MAX_VAL=9, macro undefined unless stated)
REQ-032 Wrap up: reset, then en=1, dir=1, sat=0 for 11 cycles -> count 1..9, 0, 1; ovf high exactly in the cycle after the 9->0 step.
REQ-033 Saturate down: load 2, then en=1, dir=0, sat=1 for 4 cycles -> count 1, 0, 0, 0; ovf pulses after each of the last 2 steps; zero=1 from the second step.
REQ-034 Load clamp and priority: data_in=14 with load=1 and en=1 -> count=9, ovf=0; next cycle rst=1 with load=1, data_in=5 -> count=0.
REQ-035 Direction change at boundary: count=0, dir=0, sat=0, en=1 -> count=9 and ovf=1; then dir=1 -> count=0 and ovf=1.
REQ-036 Prescale (macro defined, PRESCALE=3): en=1 for 9 cycles -> count 0, 0, 1, 1, 1, 2, 2, 2, 3; en gap of 2 cycles then resumes without losing phase; load mid-phase restarts the 3-cycle count.
REQ-037 Reset mid-operation: with count=7 and the prescaler at phase 2, rst=1 for one cycle -> count=0, ovf=0, and the next step occurs a full PRESCALE cycles later.
